// File: rtl/usb_dev_dpdm_if.sv
// rtl/usb_dev_dpdm_if.sv - DP/DM line, receive and transmit signals of the device transceiver
interface usb_dev_dpdm_if #(
    parameter int LEN_W = 7
);
    logic             dp_r;
    logic             dm_r;
    logic             dp_w;
    logic             dm_w;
    logic             oe;
    logic             rx_bit;
    logic             rx_valid;
    logic             rx_done;
    logic             rx_err;
    logic             tx_start;
    logic [LEN_W-1:0] tx_len;
    logic             tx_bit;
    logic             tx_bit_req;
    logic             tx_busy;
    logic             tx_done;

    modport slave (
        input  dp_r, dm_r, tx_start, tx_len, tx_bit,
        output dp_w, dm_w, oe, rx_bit, rx_valid, rx_done, rx_err,
               tx_bit_req, tx_busy, tx_done
    );

    modport master (
        output dp_r, dm_r, tx_start, tx_len, tx_bit,
        input  dp_w, dm_w, oe, rx_bit, rx_valid, rx_done, rx_err,
               tx_bit_req, tx_busy, tx_done
    );
endinterface

// File: rtl/usb_dev_dpdm.sv
// rtl/usb_dev_dpdm.sv - half-duplex device DP/DM transceiver; DPDM_STUFF_CHECK_EN adds the RX bit-stuff check
module usb_dev_dpdm #(
    parameter int LEN_W   = 7,
    parameter int EOP_SE0 = 2
) (
    input  logic          clk,
    input  logic          rst,
    usb_dev_dpdm_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, RX_DATA, RX_EOP, TX_SYNC, TX_DATA, TX_EOP, TX_J
    } state_t;

    state_t           state, next_state;
    logic [2:0]       sync_cnt, sync_nxt, ph_cnt, se0_cnt;
    logic [LEN_W-1:0] pay_cnt;
    logic             tx_busy_q;
    logic             is_j, is_k, is_se0, is_se1;
    logic             sync_k_exp, sync_match, sync_hit, tx_accept, stuff_viol, next_tx;

    assign is_j   =  bus.dp_r & ~bus.dm_r;
    assign is_k   = ~bus.dp_r &  bus.dm_r;
    assign is_se0 = ~bus.dp_r & ~bus.dm_r;
    assign is_se1 =  bus.dp_r &  bus.dm_r;

    // SYNC is K J K J K J K K: K on even positions and on the last one
    assign sync_k_exp = ~sync_cnt[0] | (sync_cnt == 3'd7);
    assign sync_match = sync_k_exp ? is_k : is_j;
    assign sync_hit   = sync_match && (sync_cnt == 3'd7);
    assign sync_nxt   = sync_match ? sync_cnt + 3'd1 : {2'b00, is_k};
    assign tx_accept  = bus.tx_start && (sync_cnt == 3'd0) && (bus.tx_len != '0) && !sync_hit;
    assign next_tx    = next_state inside {TX_SYNC, TX_DATA, TX_EOP, TX_J};

`ifdef DPDM_STUFF_CHECK_EN
    logic [2:0] run_cnt, run_now;
    logic       run_lvl;

    assign run_now    = (run_cnt == 3'd0 || bus.dp_r != run_lvl) ? 3'd1 : run_cnt + 3'd1;
    assign stuff_viol = (is_j || is_k) && (run_now == 3'd7);

    always_ff @(posedge clk) begin
        if (rst || state != RX_DATA) begin
            run_cnt <= 3'd0;
            run_lvl <= 1'b0;
        end else begin
            run_cnt <= run_now;
            run_lvl <= bus.dp_r;
        end
    end
`else
    assign stuff_viol = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sync_hit) next_state = RX_DATA;
                     else if (tx_accept) next_state = TX_SYNC;
            RX_DATA: if (is_se1 || stuff_viol) next_state = IDLE;
                     else if (is_se0) next_state = RX_EOP;
            RX_EOP:  if (!is_se0 || se0_cnt == 3'd6) next_state = IDLE;
            TX_SYNC: if (ph_cnt == 3'd7) next_state = TX_DATA;
            TX_DATA: if (pay_cnt == LEN_W'(1)) next_state = TX_EOP;
            TX_EOP:  if (ph_cnt == 3'(EOP_SE0 - 1)) next_state = TX_J;
            TX_J:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // sync hunting only runs while idle; any other state keeps it at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt  <= 3'd0;
            ph_cnt    <= 3'd0;
            se0_cnt   <= 3'd0;
            pay_cnt   <= '0;
            tx_busy_q <= 1'b0;
        end else begin
            sync_cnt  <= (state == IDLE && next_state == IDLE) ? sync_nxt : 3'd0;
            ph_cnt    <= (state == next_state) ? ph_cnt + 3'd1 : 3'd0;
            se0_cnt   <= (state == RX_EOP && next_state == RX_EOP) ? se0_cnt + 3'd1 : 3'd0;
            tx_busy_q <= next_tx;
            if (state == IDLE && next_state == TX_SYNC) pay_cnt <= bus.tx_len;
            else if (state == TX_DATA)                  pay_cnt <= pay_cnt - LEN_W'(1);
        end
    end

    always_comb begin
        bus.dp_w       = 1'b1;
        bus.dm_w       = 1'b0;
        bus.oe         = 1'b0;
        bus.rx_bit     = bus.dp_r;
        bus.rx_valid   = 1'b0;
        bus.rx_done    = 1'b0;
        bus.rx_err     = 1'b0;
        bus.tx_bit_req = 1'b0;
        bus.tx_busy    = tx_busy_q;
        bus.tx_done    = 1'b0;
        case (state)
            RX_DATA: begin
                bus.rx_valid = (is_j || is_k) && !stuff_viol;
                bus.rx_err   = is_se1 || stuff_viol;
            end
            RX_EOP: begin
                bus.rx_done = is_j;
                bus.rx_err  = is_k || is_se1 || (is_se0 && se0_cnt == 3'd6);
            end
            TX_SYNC: begin
                bus.oe   = 1'b1;
                bus.dp_w = ~(~ph_cnt[0] | (ph_cnt == 3'd7));
                bus.dm_w =  (~ph_cnt[0] | (ph_cnt == 3'd7));
            end
            TX_DATA: begin
                bus.oe         = 1'b1;
                bus.tx_bit_req = 1'b1;
                bus.dp_w       = bus.tx_bit;
                bus.dm_w       = ~bus.tx_bit;
            end
            TX_EOP: begin
                bus.oe   = 1'b1;
                bus.dp_w = 1'b0;
            end
            TX_J: begin
                bus.oe      = 1'b1;
                bus.tx_done = 1'b1;
            end
            default: ;
        endcase
        if (bus.oe) bus.rx_bit = 1'b0;
    end
endmodule

// File: tb/tb_usb_dev_dpdm.sv
// tb/tb_usb_dev_dpdm.sv - randomized self-checking bench for usb_dev_dpdm
module tb_usb_dev_dpdm;
    localparam int LEN_W   = 7;
    localparam int EOP_SE0 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    usb_dev_dpdm_if #(.LEN_W(LEN_W)) bus ();
    usb_dev_dpdm #(.LEN_W(LEN_W), .EOP_SE0(EOP_SE0)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct { logic r, dp, dm, start, tbit; logic [LEN_W-1:0] len; } stim_t;
    typedef struct { logic dp_w, dm_w, oe, rx_bit, rx_valid, rx_done, rx_err, req, busy, tdone; } obs_t;
    typedef struct { logic v, b, done, err; } rexp_t;
    typedef struct { logic dp_w, dm_w, oe, req, busy, done; } texp_t;

    stim_t st[$];
    obs_t  ob[$];
    rexp_t rx_exp[$];
    texp_t tx_exp[$];
    int    vectors = 0;
    int    errors  = 0;

    function automatic logic sync_k(input int i);
        return (i % 2 == 0) || (i == 7);
    endfunction

    task automatic add(input logic r, input logic dp, input logic dm, input logic start,
                       input logic [LEN_W-1:0] len, input logic tbit);
        stim_t s;
        s.r = r; s.dp = dp; s.dm = dm; s.start = start; s.len = len; s.tbit = tbit;
        st.push_back(s);
    endtask

    task automatic add_rx(input logic dp, input logic dm, input logic start, input logic [LEN_W-1:0] len,
                          input logic v, input logic b, input logic done, input logic err);
        rexp_t e;
        add(1'b0, dp, dm, start, len, 1'b0);
        e.v = v; e.b = b; e.done = done; e.err = err;
        rx_exp.push_back(e);
    endtask

    task automatic add_j(input int n);
        for (int i = 0; i < n; i++) add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic add_sync_part(input int n);
        for (int i = 0; i < n; i++) add_rx(~sync_k(i), sync_k(i), 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // payload bit i is data[n-1-i]; optional tx_start requests that must be ignored
    task automatic add_payload(input int n, input logic [31:0] data, input bit inject);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = data[n-1-i];
            add_rx(b, ~b, inject && 1'($urandom), LEN_W'($urandom_range(1, 20)), 1'b1, b, 1'b0, 1'b0);
        end
    endtask

    task automatic add_tx(input logic dp, input logic dm, input logic start, input logic [LEN_W-1:0] len,
                          input logic tbit, input logic e_dpw, input logic e_dmw, input logic e_oe,
                          input logic e_req, input logic e_busy, input logic e_done);
        texp_t e;
        add(1'b0, dp, dm, start, len, tbit);
        e.dp_w = e_dpw; e.dm_w = e_dmw; e.oe = e_oe; e.req = e_req; e.busy = e_busy; e.done = e_done;
        tx_exp.push_back(e);
    endtask

    task automatic add_tx_idle(input int n);
        for (int i = 0; i < n; i++) add_tx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // payload bit j is bits[j]; frame = SYNC, payload, SE0 x EOP_SE0, J
    task automatic add_tx_pkt(input int len, input logic [63:0] bits, input bit noise);
        int n;
        n = 8 + len + EOP_SE0 + 1;
        add_tx(1'b1, 1'b0, 1'b1, LEN_W'(len), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= n; c++) begin
            logic ndp, ndm;
            ndp = noise ? 1'($urandom) : 1'b1;
            ndm = noise ? 1'($urandom) : 1'b0;
            if (c <= 8)
                add_tx(ndp, ndm, 1'b0, '0, 1'($urandom), ~sync_k(c-1), sync_k(c-1), 1'b1, 1'b0, 1'b1, 1'b0);
            else if (c <= 8 + len)
                add_tx(ndp, ndm, 1'b0, '0, bits[c-9], bits[c-9], ~bits[c-9], 1'b1, 1'b1, 1'b1, 1'b0);
            else if (c <= 8 + len + EOP_SE0)
                add_tx(ndp, ndm, 1'b0, '0, 1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else
                add_tx(ndp, ndm, 1'b0, '0, 1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
    endtask

    task automatic play();
        ob.delete();
        foreach (st[i]) begin
            obs_t o;
            rst          = st[i].r;
            bus.dp_r     = st[i].dp;
            bus.dm_r     = st[i].dm;
            bus.tx_start = st[i].start;
            bus.tx_len   = st[i].len;
            bus.tx_bit   = st[i].tbit;
            @(negedge clk);
            o.dp_w = bus.dp_w; o.dm_w = bus.dm_w; o.oe = bus.oe; o.rx_bit = bus.rx_bit;
            o.rx_valid = bus.rx_valid; o.rx_done = bus.rx_done; o.rx_err = bus.rx_err;
            o.req = bus.tx_bit_req; o.busy = bus.tx_busy; o.tdone = bus.tx_done;
            ob.push_back(o);
            @(posedge clk);
            #1;
        end
        rst = 1'b0; bus.tx_start = 1'b0; bus.dp_r = 1'b1; bus.dm_r = 1'b0;
    endtask

    function automatic logic [31:0] run_limited(input int n);
        logic [31:0] d;
        logic        prev, b;
        int          run;
        d = '0; prev = 1'b0; run = 0;
        for (int i = 0; i < n; i++) begin
            b = 1'($urandom);
            if (i > 0 && b == prev && run == 6) b = ~prev;
            run = (i == 0 || b != prev) ? 1 : run + 1;
            prev = b;
            d[n-1-i] = b;
        end
        return d;
    endfunction

    task automatic test_reset();
        logic [8:0] got;
        st.delete();
        for (int i = 0; i < 3; i++) add(1'b1, 1'($urandom), 1'($urandom), 1'b1, LEN_W'(5), 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
        play();
        for (int i = 0; i < 4; i++) begin
            got = {ob[i].oe, ob[i].dp_w, ob[i].dm_w, ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err,
                   ob[i].req, ob[i].busy, ob[i].tdone};
            vectors++;
            if (got !== 9'b010000000) begin
                errors++;
                $display("FAIL reset cyc %0d: oe/dpw/dmw/rxv/rxd/rxe/req/busy/done got %b want 010000000", i, got);
            end
        end
    endtask

    task automatic test_rx_basic();
        st.delete(); rx_exp.delete();
        add_j(2);
        add_sync_part(8);
        add_payload(8, 32'b10100110, 1'b1);
        add_rx(1'b0, 1'b0, 1'b1, LEN_W'(4), 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b0, 1'b0, 1'b1, LEN_W'(4), 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_j(2);
        add_sync_part(4);
        add_j(1);
        add_sync_part(8);
        add_payload(5, 32'b01101, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_j(2);
        play();
        foreach (rx_exp[i]) begin
            vectors++;
            if ({ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err, ob[i].oe, ob[i].busy} !==
                {rx_exp[i].v, rx_exp[i].done, rx_exp[i].err, 2'b00}) begin
                errors++;
                $display("FAIL rx_basic cyc %0d: valid/done/err/oe/busy got %b%b%b%b%b want %b%b%b00", i,
                         ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err, ob[i].oe, ob[i].busy,
                         rx_exp[i].v, rx_exp[i].done, rx_exp[i].err);
            end
            if (rx_exp[i].v && ob[i].rx_bit !== rx_exp[i].b) begin
                errors++;
                $display("FAIL rx_basic bit cyc %0d: got %b want %b", i, ob[i].rx_bit, rx_exp[i].b);
            end
        end
    endtask

    task automatic test_rx_random();
        st.delete(); rx_exp.delete();
        for (int p = 0; p < 6; p++) begin
            int k, n, m;
            add_j($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(1, 7);
                add_sync_part(k);
                add_j((k % 2 == 1 && k < 7) ? 2 : 1);
            end
            add_sync_part(8);
            n = $urandom_range(1, 24);
            add_payload(n, run_limited(n), 1'($urandom));
            m = $urandom_range(1, 3);
            for (int i = 0; i < m; i++) add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
            add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
            add_j(2);
        end
        play();
        foreach (rx_exp[i]) begin
            vectors++;
            if ({ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err, ob[i].oe, ob[i].busy} !==
                {rx_exp[i].v, rx_exp[i].done, rx_exp[i].err, 2'b00}) begin
                errors++;
                $display("FAIL rx_random cyc %0d: valid/done/err/oe/busy got %b%b%b%b%b want %b%b%b00", i,
                         ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err, ob[i].oe, ob[i].busy,
                         rx_exp[i].v, rx_exp[i].done, rx_exp[i].err);
            end
            if (rx_exp[i].v && ob[i].rx_bit !== rx_exp[i].b) begin
                errors++;
                $display("FAIL rx_random bit cyc %0d: got %b want %b", i, ob[i].rx_bit, rx_exp[i].b);
            end
        end
    endtask

    task automatic test_rx_errors();
        st.delete(); rx_exp.delete();
        add_sync_part(8);
        add_payload(3, 32'b101, 1'b0);
        add_rx(1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_j(2);
        add_sync_part(8);
        add_payload(2, 32'b10, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_j(2);
        add_sync_part(8);
        add_payload(2, 32'b01, 1'b0);
        for (int i = 0; i < 7; i++) add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
        add_j(2);
        add_sync_part(8);
        add_payload(1, 32'b1, 1'b0);
        for (int i = 0; i < 7; i++) add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
        add_j(2);
        play();
        foreach (rx_exp[i]) begin
            vectors++;
            if ({ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err} !== {rx_exp[i].v, rx_exp[i].done, rx_exp[i].err}) begin
                errors++;
                $display("FAIL rx_errors cyc %0d: valid/done/err got %b%b%b want %b%b%b", i,
                         ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err, rx_exp[i].v, rx_exp[i].done, rx_exp[i].err);
            end
        end
    endtask

    task automatic test_stuff_run();
        st.delete(); rx_exp.delete();
        add_sync_part(8);
`ifdef DPDM_STUFF_CHECK_EN
        for (int i = 0; i < 6; i++) add_rx(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
`else
        for (int i = 0; i < 7; i++) add_rx(1'b1, 1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_rx(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
        add_j(2);
        play();
        foreach (rx_exp[i]) begin
            vectors++;
            if ({ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err} !== {rx_exp[i].v, rx_exp[i].done, rx_exp[i].err}) begin
                errors++;
                $display("FAIL stuff_run cyc %0d: valid/done/err got %b%b%b want %b%b%b", i,
                         ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err, rx_exp[i].v, rx_exp[i].done, rx_exp[i].err);
            end
        end
    endtask

    task automatic test_tx_basic();
        int oe_cnt;
        st.delete(); tx_exp.delete();
        add_tx_pkt(5, 64'b01011, 1'b0);
        add_tx_idle(2);
        play();
        oe_cnt = 0;
        foreach (tx_exp[i]) begin
            if (ob[i].oe === 1'b1) oe_cnt++;
            vectors++;
            if ({ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone, ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err} !==
                {tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done, 3'b000}) begin
                errors++;
                $display("FAIL tx_basic cyc %0d: dpw/dmw/oe/req/busy/done/rx got %b%b%b%b%b%b%b%b%b want %b%b%b%b%b%b000", i,
                         ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone, ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err,
                         tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done);
            end
        end
        vectors++;
        if (oe_cnt != 16) begin
            errors++;
            $display("FAIL tx_basic oe_cycles: got %0d want 16", oe_cnt);
        end
    endtask

    task automatic test_tx_reject();
        st.delete(); tx_exp.delete();
        add_tx(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_tx(1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_tx(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_tx(1'b1, 1'b0, 1'b1, LEN_W'(5), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add_tx_idle(12);
        play();
        foreach (tx_exp[i]) begin
            vectors++;
            if ({ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone} !==
                {tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done}) begin
                errors++;
                $display("FAIL tx_reject cyc %0d: dpw/dmw/oe/req/busy/done got %b%b%b%b%b%b want 100000", i,
                         ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone);
            end
        end
    endtask

    task automatic test_tx_random();
        int oe_cnt, oe_want;
        st.delete(); tx_exp.delete();
        oe_want = 0;
        for (int p = 0; p < 4; p++) begin
            int len;
            len = $urandom_range(1, 40);
            oe_want += 8 + len + EOP_SE0 + 1;
            add_tx_idle($urandom_range(0, 3));
            add_tx_pkt(len, {$urandom, $urandom}, 1'b1);
        end
        add_tx_idle(2);
        play();
        oe_cnt = 0;
        foreach (tx_exp[i]) begin
            if (ob[i].oe === 1'b1) oe_cnt++;
            vectors++;
            if ({ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone, ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err} !==
                {tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done, 3'b000}) begin
                errors++;
                $display("FAIL tx_random cyc %0d: dpw/dmw/oe/req/busy/done/rx got %b%b%b%b%b%b%b%b%b want %b%b%b%b%b%b000", i,
                         ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone, ob[i].rx_valid, ob[i].rx_done, ob[i].rx_err,
                         tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done);
            end
        end
        vectors++;
        if (oe_cnt != oe_want) begin
            errors++;
            $display("FAIL tx_random oe_cycles: got %0d want %0d", oe_cnt, oe_want);
        end
    endtask

    task automatic test_back_to_back();
        st.delete(); tx_exp.delete();
        add_tx_pkt(1, 64'b1, 1'b1);
        add_tx_pkt(3, 64'b010, 1'b1);
        add_tx_idle(2);
        play();
        foreach (tx_exp[i]) begin
            vectors++;
            if ({ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone} !==
                {tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done}) begin
                errors++;
                $display("FAIL back_to_back cyc %0d: dpw/dmw/oe/req/busy/done got %b%b%b%b%b%b want %b%b%b%b%b%b", i,
                         ob[i].dp_w, ob[i].dm_w, ob[i].oe, ob[i].req, ob[i].busy, ob[i].tdone,
                         tx_exp[i].dp_w, tx_exp[i].dm_w, tx_exp[i].oe, tx_exp[i].req, tx_exp[i].busy, tx_exp[i].done);
            end
        end
    endtask

    task automatic test_reset_mid_tx();
        int oe_cnt;
        st.delete();
        add(1'b0, 1'b1, 1'b0, 1'b1, LEN_W'(20), 1'b0);
        for (int c = 1; c <= 11; c++) add(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'($urandom));
        add(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b1, LEN_W'(3), 1'b0);
        for (int c = 14; c <= 29; c++) add(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        play();
        vectors++;
        if ({ob[12].oe, ob[12].req} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_tx in_data: oe/req got %b%b want 11", ob[12].oe, ob[12].req);
        end
        vectors++;
        if ({ob[13].oe, ob[13].dp_w, ob[13].dm_w, ob[13].busy, ob[13].req} !== 5'b01000) begin
            errors++;
            $display("FAIL reset_mid_tx after_rst: oe/dpw/dmw/busy/req got %b%b%b%b%b want 01000",
                     ob[13].oe, ob[13].dp_w, ob[13].dm_w, ob[13].busy, ob[13].req);
        end
        vectors++;
        if ({ob[14].oe, ob[14].dp_w, ob[14].dm_w, ob[14].busy} !== 4'b1011) begin
            errors++;
            $display("FAIL reset_mid_tx restart: oe/dpw/dmw/busy got %b%b%b%b want 1011",
                     ob[14].oe, ob[14].dp_w, ob[14].dm_w, ob[14].busy);
        end
        vectors++;
        if ({ob[27].tdone, ob[28].oe} !== 2'b10) begin
            errors++;
            $display("FAIL reset_mid_tx done: done27/oe28 got %b%b want 10", ob[27].tdone, ob[28].oe);
        end
        oe_cnt = 0;
        for (int i = 13; i <= 29; i++) if (ob[i].oe === 1'b1) oe_cnt++;
        vectors++;
        if (oe_cnt != 14) begin
            errors++;
            $display("FAIL reset_mid_tx oe_cycles: got %0d want 14", oe_cnt);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.dp_r = 1'b1; bus.dm_r = 1'b0;
        bus.tx_start = 1'b0; bus.tx_len = '0; bus.tx_bit = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_rx_basic();
        test_rx_random();
        test_rx_errors();
        test_stuff_run();
        test_tx_basic();
        test_tx_reject();
        test_tx_random();
        test_back_to_back();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
